// File: rtl/ascon_round_if.sv
// Bus bundle for the iterative Ascon round datapath: round operands and controls in, state/tag/cipher out.
// The master drives the inputs, and the slave (the datapath) drives the outputs.
interface ascon_round_if;
  logic [319:0] state_in_i;
  logic [63:0]  data64_i;
  logic [255:0] data256_i;
  logic         input_select_i;
  logic         xorup_select_i;
  logic [1:0]   xordn_select_i;
  logic         ena_reg_i;
  logic         ena_i;
  logic         init_a_i;
  logic         init_b_i;
  logic [3:0]   round_o;
  logic [319:0] state_out_o;
  logic [63:0]  cipher_o;
  logic [127:0] tag_o;

  modport master (
    output state_in_i, data64_i, data256_i, input_select_i, xorup_select_i,
           xordn_select_i, ena_reg_i, ena_i, init_a_i, init_b_i,
    input  round_o, state_out_o, cipher_o, tag_o
  );

  modport slave (
    input  state_in_i, data64_i, data256_i, input_select_i, xorup_select_i,
           xordn_select_i, ena_reg_i, ena_i, init_a_i, init_b_i,
    output round_o, state_out_o, cipher_o, tag_o
  );
endinterface

// File: rtl/ascon_round_datapath.sv
// One Ascon permutation round per clock on a registered 320-bit state, with a 4-bit round counter.
// State and counter update one cycle after their enables; cipher_o is combinational. There is no backpressure.
module ascon_round_datapath (
  input logic          clock_i,
  input logic          resetb_i,
  ascon_round_if.slave bus
);

  logic [319:0] state_q;
  logic [3:0]   round_q;

  logic [319:0] rin;
  logic [63:0]  a0, a1, a2, a3, a4;
  logic [63:0]  b0, b1, b2, b3, b4;
  logic [63:0]  t0, t1, t2, t3, t4;
  logic [63:0]  s0, s1, s2, s3, s4;
  logic [63:0]  l0, l1, l2, l3, l4;
  logic [319:0] lin;
  logic [319:0] dn;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign rin = bus.input_select_i ? state_q : bus.state_in_i;

  // Upstream XOR on x0, then the round constant on the low byte of x2.
  assign a0 = rin[319:256] ^ (bus.xorup_select_i ? bus.data64_i : 64'h0);
  assign a1 = rin[255:192];
  assign a2 = rin[191:128] ^ {56'h0, ~round_q, round_q};
  assign a3 = rin[127:64];
  assign a4 = rin[63:0];

  // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once.
  assign b0 = a0 ^ a4;
  assign b4 = a4 ^ a3;
  assign b2 = a2 ^ a1;
  assign b1 = a1;
  assign b3 = a3;
  assign t0 = b0 ^ (~b1 & b2);
  assign t1 = b1 ^ (~b2 & b3);
  assign t2 = b2 ^ (~b3 & b4);
  assign t3 = b3 ^ (~b4 & b0);
  assign t4 = b4 ^ (~b0 & b1);
  assign s1 = t1 ^ t0;
  assign s0 = t0 ^ t4;
  assign s3 = t3 ^ t2;
  assign s2 = ~t2;
  assign s4 = t4;

  assign l0 = s0 ^ ror(s0, 19) ^ ror(s0, 28);
  assign l1 = s1 ^ ror(s1, 61) ^ ror(s1, 39);
  assign l2 = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
  assign l3 = s3 ^ ror(s3, 10) ^ ror(s3, 17);
  assign l4 = s4 ^ ror(s4, 7)  ^ ror(s4, 41);
  assign lin = {l0, l1, l2, l3, l4};

  assign dn = lin ^ {64'h0, (bus.xordn_select_i[0] ? bus.data256_i : 256'h0)}
                  ^ {319'h0, bus.xordn_select_i[1]};

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q <= '0;
    end else if (bus.ena_reg_i) begin
      state_q <= dn;
    end
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      round_q <= 4'd0;
    end else if (bus.init_a_i) begin
      round_q <= 4'd0;
    end else if (bus.init_b_i) begin
      round_q <= 4'd6;
    end else if (bus.ena_i) begin
      round_q <= round_q + 4'd1;
    end
  end

  assign bus.round_o     = round_q;
  assign bus.state_out_o = state_q;
  assign bus.tag_o       = state_q[127:0];
  assign bus.cipher_o    = a0;

endmodule

// File: tb/tb_ascon_round_datapath.sv
// Randomised and directed bench for ascon_round_datapath against a word/table-level Ascon model.
module tb_ascon_round_datapath;

  logic clk = 1'b0;
  logic rst;
  ascon_round_if bus ();

  ascon_round_datapath dut (
    .clock_i (clk),
    .resetb_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [4:0] sbox_tbl [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  logic [319:0] m_state = '0;
  logic [3:0]   m_round = 4'd0;

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    int          rr [5][2];
    rr = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64 * w -: 64];
    x[2][7:0] = x[2][7:0] ^ {~r, r};
    for (int b = 0; b < 64; b++) begin
      v = sbox_tbl[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
      for (int w = 0; w < 5; w++) y[w][b] = v[4 - w];
    end
    for (int w = 0; w < 5; w++) y[w] = y[w] ^ rot(y[w], rr[w][0]) ^ rot(y[w], rr[w][1]);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0;
    bus.state_in_i = '0;
    bus.data64_i = '0;
    bus.data256_i = '0;
    bus.input_select_i = 1'b0;
    bus.xorup_select_i = 1'b0;
    bus.xordn_select_i = 2'b00;
    bus.ena_reg_i = 1'b0;
    bus.ena_i = 1'b0;
    bus.init_a_i = 1'b0;
    bus.init_b_i = 1'b0;
  endtask

  // Predict the next state from the current inputs, clock once, then compare.
  task automatic tick();
    logic [319:0] s, nxt;
    logic [3:0]   nr;
    #1;
    s = bus.input_select_i ? m_state : bus.state_in_i;
    if (bus.xorup_select_i) s[319:256] = s[319:256] ^ bus.data64_i;
    check_eq("cipher", {256'h0, bus.cipher_o}, {256'h0, s[319:256]});
    nxt = model_round(s, m_round);
    if (bus.xordn_select_i[0]) nxt[255:0] = nxt[255:0] ^ bus.data256_i;
    if (bus.xordn_select_i[1]) nxt[0] = ~nxt[0];
    if (rst) nxt = '0;
    else if (!bus.ena_reg_i) nxt = m_state;
    if (rst || bus.init_a_i) nr = 4'd0;
    else if (bus.init_b_i) nr = 4'd6;
    else if (bus.ena_i) nr = m_round + 4'd1;
    else nr = m_round;
    @(posedge clk);
    #1;
    m_state = nxt;
    m_round = nr;
    check_eq("state", bus.state_out_o, m_state);
    check_eq("tag", {192'h0, bus.tag_o}, {192'h0, m_state[127:0]});
    check_eq("round", {316'h0, bus.round_o}, {316'h0, m_round});
  endtask

  logic [319:0] saved;
  logic [319:0] base;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    check_eq("rst_state", bus.state_out_o, 320'h0);
    check_eq("rst_round", {316'h0, bus.round_o}, 320'h0);
    rst = 1'b0;

    // Counter: p12 run, p6 start, wrap from 15, init priority.
    bus.init_a_i = 1'b1; tick(); bus.init_a_i = 1'b0;
    bus.ena_i = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check_eq("cnt_step", {316'h0, bus.round_o}, i);
    end
    bus.init_b_i = 1'b1; tick(); bus.init_b_i = 1'b0;
    check_eq("cnt_initb", {316'h0, bus.round_o}, 320'd6);
    for (int i = 0; i < 9; i++) tick();
    check_eq("cnt_15", {316'h0, bus.round_o}, 320'd15);
    tick();
    check_eq("cnt_wrap", {316'h0, bus.round_o}, 320'd0);
    bus.init_a_i = 1'b1; bus.init_b_i = 1'b1; tick();
    check_eq("cnt_both", {316'h0, bus.round_o}, 320'd0);
    idle();

    // Single round of the all-zero state with constant 0xF0.
    bus.init_a_i = 1'b1; tick(); idle();
    bus.ena_reg_i = 1'b1; bus.ena_i = 1'b1; tick();
    check_eq("zero_round", bus.state_out_o, model_round(320'h0, 4'd0));
    idle();

    // Ascon-128 initialisation: 12 rounds, key folded in on the last one.
    bus.init_a_i = 1'b1; tick(); idle();
    bus.state_in_i = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
                      64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    base = bus.state_in_i;
    bus.ena_i = 1'b1; bus.ena_reg_i = 1'b1;
    tick();
    bus.input_select_i = 1'b1;
    for (int i = 1; i < 11; i++) tick();
    bus.xordn_select_i = 2'b01;
    bus.data256_i = {128'h0, 128'h8a55114d1cb6a9a2be263d4d7aecaaff};
    tick();
    for (int i = 0; i < 12; i++) base = model_round(base, i[3:0]);
    base[127:0] = base[127:0] ^ 128'h8a55114d1cb6a9a2be263d4d7aecaaff;
    check_eq("init_p12", bus.state_out_o, base);
    idle();

    // Upstream XOR visible on cipher_o.
    bus.state_in_i = rand320();
    bus.xorup_select_i = 1'b1;
    bus.data64_i = 64'h0123456789ABCDEF;
    #1;
    check_eq("xorup", {256'h0, bus.cipher_o}, {256'h0, bus.state_in_i[319:256] ^ 64'h0123456789ABCDEF});
    idle();

    // Mode 10 differs from mode 00 only in bit 0.
    bus.state_in_i = rand320();
    bus.init_a_i = 1'b1; tick(); bus.init_a_i = 1'b0;
    bus.ena_reg_i = 1'b1; tick();
    saved = bus.state_out_o;
    bus.ena_reg_i = 1'b0; bus.init_a_i = 1'b1; tick(); bus.init_a_i = 1'b0;
    bus.ena_reg_i = 1'b1; bus.xordn_select_i = 2'b10; tick();
    check_eq("xordn_bit0", bus.state_out_o ^ saved, 320'h1);
    idle();

    // Hold with ena_reg_i low while everything else toggles.
    saved = bus.state_out_o;
    for (int i = 0; i < 5; i++) begin
      bus.state_in_i = rand320();
      bus.data64_i = {$urandom, $urandom};
      bus.data256_i = rand320();
      bus.input_select_i = 1'($urandom);
      bus.xorup_select_i = 1'($urandom);
      bus.xordn_select_i = 2'($urandom);
      bus.ena_i = 1'($urandom);
      tick();
    end
    check_eq("hold_state", bus.state_out_o, saved);
    check_eq("hold_tag", {192'h0, bus.tag_o}, {192'h0, saved[127:0]});

    // Fully random traffic.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      bus.state_in_i = rand320();
      bus.data64_i = {$urandom, $urandom};
      bus.data256_i = rand320();
      bus.input_select_i = 1'($urandom);
      bus.xorup_select_i = 1'($urandom);
      bus.xordn_select_i = 2'($urandom);
      bus.ena_reg_i = ($urandom_range(0, 3) != 0);
      bus.ena_i = 1'($urandom);
      bus.init_a_i = ($urandom_range(0, 7) == 0);
      bus.init_b_i = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
